// File: rtl/pck_inj_scheduler.sv
// Packet injector scheduler.
// N traffic requesters share one packet injector. A round-robin arbiter picks
// one eligible requester per IDLE cycle. A legal winner has its packet fields
// captured and written to the injector (ISSUE). One GAP cycle follows so the
// injector's per-VC ready can reflect the new packet before the next grant.
// An illegal winner (size too small or VC out of range) is acknowledged with
// an error pulse and dropped without being issued.
//
// Handshake: a requester raises req_valid[i] and holds req_vc/req_size/
// req_dest/req_data stable until it sees req_ack[i]. req_ack[i] is a
// single-cycle combinational pulse in the grant cycle. req_err[i] pulses
// together with req_ack[i] when the request was rejected. The requester may
// drop req_valid[i] at any time before ack without side effects.
module pck_inj_scheduler #(
  parameter int N        = 4,
  parameter int V        = 2,
  parameter int EAw      = 8,
  parameter int PCK_SIZw = 5,
  parameter int Dw       = 32,
  parameter int MIN_SIZE = 2,
  localparam int Vw      = (V > 1) ? $clog2(V) : 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [N-1:0]          req_valid,
  input  logic [N*Vw-1:0]       req_vc,
  input  logic [N*PCK_SIZw-1:0] req_size,
  input  logic [N*EAw-1:0]      req_dest,
  input  logic [N*Dw-1:0]       req_data,
  output logic [N-1:0]          req_ack,
  output logic [N-1:0]          req_err,
  input  logic [V-1:0]          inj_ready,
  output logic                  pck_wr,
  output logic [V-1:0]          pck_vc,
  output logic [PCK_SIZw-1:0]   pck_size,
  output logic [EAw-1:0]        pck_endp_addr,
  output logic [Dw-1:0]         pck_data,
  output logic                  busy,
  output logic [15:0]           issued_cnt,
  output logic [1:0]            dbg_state
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t state_q, state_d;

  // Arbitration pointer and issue counter.
  logic [PW-1:0] ptr_q, ptr_d;
  logic [15:0]   cnt_q, cnt_d;

  // Registered injector interface.
  logic                pck_wr_q, pck_wr_d;
  logic [V-1:0]        pck_vc_q, pck_vc_d;
  logic [PCK_SIZw-1:0] pck_size_q, pck_size_d;
  logic [EAw-1:0]      pck_dest_q, pck_dest_d;
  logic [Dw-1:0]       pck_data_q, pck_data_d;

  // Per-requester decode.
  logic [N-1:0] illegal;
  logic [N-1:0] vc_ready;
  logic [N-1:0] eligible;

  // Arbitration result.
  logic                win_found;
  logic [PW-1:0]       win_idx;
  int                  arb_idx;
  logic                win_illegal;
  logic [Vw-1:0]       win_vc;
  logic [PCK_SIZw-1:0] win_size;
  logic [EAw-1:0]      win_dest;
  logic [Dw-1:0]       win_data;

  // Grant strobes.
  logic grant;
  logic capture;

  // ---------------------------------------------------------------------------
  // Per-requester legality and readiness.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < N; g++) begin : g_req
    logic [Vw-1:0]       vc_g;
    logic [PCK_SIZw-1:0] size_g;
    logic                rdy_g;

    assign vc_g   = req_vc[g*Vw +: Vw];
    assign size_g = req_size[g*PCK_SIZw +: PCK_SIZw];

    // A request is illegal if it is shorter than the minimum packet or names
    // a VC that does not exist; illegal requests are always eligible so they
    // get flushed out with an error instead of blocking forever.
    assign illegal[g] = (32'(size_g) < $unsigned(MIN_SIZE)) ||
                        (32'(vc_g) >= $unsigned(V));

    // Look up the injector ready bit of the requested VC; VCs that do not
    // exist read as not ready.
    always_comb begin
      rdy_g = 1'b0;
      for (int v = 0; v < V; v++) begin
        if (vc_g == Vw'(v)) rdy_g = inj_ready[v];
      end
    end

    assign vc_ready[g] = rdy_g;
    assign eligible[g] = req_valid[g] & (illegal[g] | vc_ready[g]);
  end

  // ---------------------------------------------------------------------------
  // Round-robin arbitration.
  // ---------------------------------------------------------------------------

  // Search for the first eligible requester at or after the pointer, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    arb_idx   = 0;
    for (int k = 0; k < N; k++) begin
      arb_idx = (int'(ptr_q) + k) % N;
      if (!win_found && eligible[arb_idx]) begin
        win_found = 1'b1;
        win_idx   = PW'(arb_idx);
      end
    end
  end

  // Select the winning requester's fields.
  always_comb begin
    win_illegal = 1'b0;
    win_vc      = '0;
    win_size    = '0;
    win_dest    = '0;
    win_data    = '0;
    for (int i = 0; i < N; i++) begin
      if (win_idx == PW'(i)) begin
        win_illegal = illegal[i];
        win_vc      = req_vc[i*Vw +: Vw];
        win_size    = req_size[i*PCK_SIZw +: PCK_SIZw];
        win_dest    = req_dest[i*EAw +: EAw];
        win_data    = req_data[i*Dw +: Dw];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Control FSM.
  // ---------------------------------------------------------------------------

  // State register; reset abandons any packet in flight.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state: a legal grant starts ISSUE, which is always followed by GAP.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (win_found && !win_illegal) state_d = S_ISSUE;
      end
      S_ISSUE: state_d = S_GAP;
      S_GAP:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs: grants only happen in IDLE and never while reset is held.
  always_comb begin
    req_ack = '0;
    req_err = '0;
    grant   = 1'b0;
    busy    = (state_q != S_IDLE);
    if (reset && (state_q == S_IDLE) && win_found) begin
      grant            = 1'b1;
      req_ack[win_idx] = 1'b1;
      req_err[win_idx] = win_illegal;
    end
  end

  assign capture = grant & ~win_illegal;

  // ---------------------------------------------------------------------------
  // Datapath.
  // ---------------------------------------------------------------------------

  // Next values for pointer, counter and injector fields.
  always_comb begin
    ptr_d      = ptr_q;
    cnt_d      = cnt_q;
    pck_wr_d   = capture;
    pck_vc_d   = pck_vc_q;
    pck_size_d = pck_size_q;
    pck_dest_d = pck_dest_q;
    pck_data_d = pck_data_q;

    if (grant) begin
      ptr_d = (win_idx == PW'(N - 1)) ? '0 : win_idx + 1'b1;
    end

    // The counter advances once per packet actually written.
    if (state_q == S_ISSUE) begin
      cnt_d = cnt_q + 16'd1;
    end

    if (capture) begin
      for (int v = 0; v < V; v++) begin
        pck_vc_d[v] = (win_vc == Vw'(v));
      end
      pck_size_d = win_size;
      pck_dest_d = win_dest;
      pck_data_d = win_data;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q      <= '0;
      cnt_q      <= '0;
      pck_wr_q   <= 1'b0;
      pck_vc_q   <= '0;
      pck_size_q <= '0;
      pck_dest_q <= '0;
      pck_data_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      cnt_q      <= cnt_d;
      pck_wr_q   <= pck_wr_d;
      pck_vc_q   <= pck_vc_d;
      pck_size_q <= pck_size_d;
      pck_dest_q <= pck_dest_d;
      pck_data_q <= pck_data_d;
    end
  end

  assign pck_wr        = pck_wr_q;
  assign pck_vc        = pck_vc_q;
  assign pck_size      = pck_size_q;
  assign pck_endp_addr = pck_dest_q;
  assign pck_data      = pck_data_q;
  assign issued_cnt    = cnt_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_pck_inj_scheduler.sv
// Testbench for pck_inj_scheduler: directed scenarios, a cycle-level
// behavioural model compared every cycle, and literal expectations per scenario.
module tb_pck_inj_scheduler;

  localparam int N        = 4;
  localparam int V        = 2;
  localparam int VW       = 1;
  localparam int EAW      = 8;
  localparam int PSW      = 5;
  localparam int DW       = 32;
  localparam int MIN_SIZE = 2;

  // ---------------------------------------------------------------------------
  // Clock / reset and DUT
  // ---------------------------------------------------------------------------
  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [N-1:0]     req_valid = '0;
  logic [N*VW-1:0]  req_vc = '0;
  logic [N*PSW-1:0] req_size = '0;
  logic [N*EAW-1:0] req_dest = '0;
  logic [N*DW-1:0]  req_data = '0;
  logic [V-1:0]     inj_ready = '0;
  logic [N-1:0]     req_ack;
  logic [N-1:0]     req_err;
  logic             pck_wr;
  logic [V-1:0]     pck_vc;
  logic [PSW-1:0]   pck_size;
  logic [EAW-1:0]   pck_endp_addr;
  logic [DW-1:0]    pck_data;
  logic             busy;
  logic [15:0]      issued_cnt;
  logic [1:0]       dbg_state;

  always #5 clk = ~clk;

  pck_inj_scheduler #(
    .N(N), .V(V), .EAw(EAW), .PCK_SIZw(PSW), .Dw(DW), .MIN_SIZE(MIN_SIZE)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_vc(req_vc), .req_size(req_size),
    .req_dest(req_dest), .req_data(req_data),
    .req_ack(req_ack), .req_err(req_err),
    .inj_ready(inj_ready),
    .pck_wr(pck_wr), .pck_vc(pck_vc), .pck_size(pck_size),
    .pck_endp_addr(pck_endp_addr), .pck_data(pck_data),
    .busy(busy), .issued_cnt(issued_cnt), .dbg_state(dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and check helper
  // ---------------------------------------------------------------------------
  int n_chk  = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a requester wins from the round-robin pointer; a legal
  // win makes the block unavailable for two cycles, the first of which writes.
  // ---------------------------------------------------------------------------
  int             m_ptr  = 0;
  int             m_cool = 0;
  logic [15:0]    m_cnt  = '0;
  logic [V-1:0]   m_vc   = '0;
  logic [PSW-1:0] m_size = '0;
  logic [EAW-1:0] m_dest = '0;
  logic [DW-1:0]  m_data = '0;

  function automatic logic [VW-1:0] f_vc(input int i);
    return req_vc[i*VW +: VW];
  endfunction
  function automatic logic [PSW-1:0] f_size(input int i);
    return req_size[i*PSW +: PSW];
  endfunction
  function automatic bit f_illegal(input int i);
    return (int'(f_size(i)) < MIN_SIZE) || (int'(f_vc(i)) >= V);
  endfunction

  always @(negedge clk) begin : model_cmp
    logic [N-1:0] e_ack;
    logic [N-1:0] e_err;
    int win;
    int idx;
    if (chk_en) begin
      e_ack = '0;
      e_err = '0;
      win   = -1;
      if (reset && m_cool == 0) begin
        for (int k = 0; k < N; k++) begin
          idx = (m_ptr + k) % N;
          if (win < 0 && req_valid[idx] && (f_illegal(idx) || inj_ready[f_vc(idx)])) win = idx;
        end
      end
      if (win >= 0) begin
        e_ack[win] = 1'b1;
        e_err[win] = f_illegal(win);
      end

      check("m_ack",  64'(req_ack),       64'(e_ack));
      check("m_err",  64'(req_err),       64'(e_err));
      check("m_wr",   64'(pck_wr),        64'(m_cool == 2));
      check("m_busy", 64'(busy),          64'(m_cool != 0));
      check("m_cnt",  64'(issued_cnt),    64'(m_cnt));
      check("m_vc",   64'(pck_vc),        64'(m_vc));
      check("m_size", 64'(pck_size),      64'(m_size));
      check("m_dest", 64'(pck_endp_addr), 64'(m_dest));
      check("m_data", 64'(pck_data),      64'(m_data));

      if (!reset) begin
        m_ptr = 0; m_cool = 0; m_cnt = '0;
        m_vc = '0; m_size = '0; m_dest = '0; m_data = '0;
      end else if (m_cool > 0) begin
        if (m_cool == 2) m_cnt = m_cnt + 16'd1;
        m_cool = m_cool - 1;
      end else if (win >= 0) begin
        m_ptr = (win + 1) % N;
        if (!f_illegal(win)) begin
          m_cool = 2;
          m_vc = '0;
          m_vc[f_vc(win)] = 1'b1;
          m_size = f_size(win);
          m_dest = req_dest[win*EAW +: EAW];
          m_data = req_data[win*DW +: DW];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [VW-1:0] vc, input logic [PSW-1:0] sz,
                         input logic [EAW-1:0] d, input logic [DW-1:0] dat);
    req_valid[i]          = 1'b1;
    req_vc[i*VW +: VW]    = vc;
    req_size[i*PSW +: PSW] = sz;
    req_dest[i*EAW +: EAW] = d;
    req_data[i*DW +: DW]  = dat;
  endtask

  task automatic clr_req(input int i);
    req_valid[i] = 1'b0;
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------------------------------------------------------------------
  // Directed scenarios
  // ---------------------------------------------------------------------------
  logic [N-1:0] ack_log [13];
  logic         wr_log  [13];
  logic [N-1:0] cont_ack_exp [13];

  initial begin
    cont_ack_exp = '{4'b0001, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 4'b0000, 4'b0100,
                     4'b0000, 4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0001};

    // Reset
    reset = 1'b0;
    inj_ready = 2'b11;
    cyc();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_ack",  64'(req_ack),    64'(0));
    check("rst_wr",   64'(pck_wr),     64'(0));
    check("rst_cnt",  64'(issued_cnt), 64'(0));
    check("rst_busy", 64'(busy),       64'(0));
    check("rst_vc",   64'(pck_vc),     64'(0));
    check("rst_data", 64'(pck_data),   64'(0));
    cyc();

    // Contention: all requesters on vc0, size 4
    cyc();
    reset = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 1'b0, 5'd4, EAW'(i + 1), 32'h1000_0000 + DW'(i));
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      ack_log[c] = req_ack;
      wr_log[c]  = pck_wr;
    end
    cyc();
    for (int i = 0; i < N; i++) clr_req(i);
    @(negedge clk);
    @(negedge clk);
    check("cont_cnt", 64'(issued_cnt), 64'(5));
    for (int c = 0; c < 13; c++) begin
      check("cont_ack", 64'(ack_log[c]), 64'(cont_ack_exp[c]));
      check("cont_wr",  64'(wr_log[c]),  64'(c % 3 == 1));
    end

    // Blocked VC: requester 1 waits on vc1 while requester 2 goes on vc0
    cyc();
    inj_ready = 2'b01;
    set_req(1, 1'b1, 5'd3, 8'h21, 32'h0000_0111);
    set_req(2, 1'b0, 5'd3, 8'h22, 32'h0000_0222);
    @(negedge clk);
    check("blk_first", 64'(req_ack), 64'(4'b0100));
    cyc();
    clr_req(2);
    cyc();
    cyc();
    @(negedge clk);
    check("blk_wait", 64'(req_ack), 64'(4'b0000));
    check("blk_idle", 64'(busy),    64'(0));
    cyc();
    inj_ready = 2'b11;
    @(negedge clk);
    check("blk_release", 64'(req_ack), 64'(4'b0010));
    cyc();
    clr_req(1);
    cyc();

    // Field capture
    cyc();
    set_req(2, 1'b1, 5'd3, 8'h15, 32'hDEAD_BEEF);
    @(negedge clk);
    check("cap_ack", 64'(req_ack), 64'(4'b0100));
    cyc();
    clr_req(2);
    @(negedge clk);
    check("cap_wr",   64'(pck_wr),        64'(1));
    check("cap_vc",   64'(pck_vc),        64'(2'b10));
    check("cap_dest", 64'(pck_endp_addr), 64'(8'h15));
    check("cap_data", 64'(pck_data),      64'(32'hDEAD_BEEF));
    check("cap_size", 64'(pck_size),      64'(5'd3));
    cyc();

    // Illegal size on requester 3
    cyc();
    set_req(3, 1'b0, 5'd1, 8'h33, 32'h0000_0333);
    @(negedge clk);
    check("ill_ack", 64'(req_ack), 64'(4'b1000));
    check("ill_err", 64'(req_err), 64'(4'b1000));
    cyc();
    clr_req(3);
    @(negedge clk);
    check("ill_wr",   64'(pck_wr),     64'(0));
    check("ill_busy", 64'(busy),       64'(0));
    check("ill_cnt",  64'(issued_cnt), 64'(8));
    check("ill_size", 64'(pck_size),   64'(5'd3));
    cyc();
    set_req(0, 1'b0, 5'd2, 8'h40, 32'h0000_0400);
    set_req(2, 1'b0, 5'd2, 8'h42, 32'h0000_0420);
    @(negedge clk);
    check("ill_ptr", 64'(req_ack), 64'(4'b0001));
    cyc();
    clr_req(0);
    clr_req(2);
    cyc();

    // Reset during ISSUE
    cyc();
    set_req(0, 1'b0, 5'd4, 8'h50, 32'h0000_0500);
    set_req(1, 1'b0, 5'd4, 8'h51, 32'h0000_0510);
    @(negedge clk);
    check("ri_ack", 64'(req_ack), 64'(4'b0010));
    cyc();
    reset = 1'b0;
    @(negedge clk);
    check("ri_wr_issue", 64'(pck_wr), 64'(1));
    cyc();
    @(negedge clk);
    check("ri_wr",   64'(pck_wr),     64'(0));
    check("ri_cnt",  64'(issued_cnt), 64'(0));
    check("ri_busy", 64'(busy),       64'(0));
    check("ri_ack0", 64'(req_ack),    64'(0));
    cyc();
    reset = 1'b1;
    @(negedge clk);
    check("ri_first", 64'(req_ack), 64'(4'b0001));
    cyc();
    clr_req(0);
    clr_req(1);
    cyc();

    // Counter wrap
    cyc();
    force dut.cnt_q = 16'hFFFF;
    m_cnt = 16'hFFFF;
    #1;
    release dut.cnt_q;
    cyc();
    set_req(2, 1'b1, 5'd2, 8'h60, 32'h0000_0600);
    @(negedge clk);
    check("wrap_ack", 64'(req_ack), 64'(4'b0100));
    cyc();
    clr_req(2);
    cyc();
    @(negedge clk);
    check("wrap_cnt", 64'(issued_cnt), 64'(16'h0000));
    cyc();
    cyc();

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pck_inj_scheduler.md
PCK_INJ_SCHEDULER -- requirements
Module: pck_inj_scheduler

Interface
REQ-001 SHALL have parameter N, default 4: number of traffic requesters sharing one packet injector.
REQ-002 SHALL have parameter V, default 2: number of virtual channels; Vw = max(1, ceil(log2 V)).
REQ-003 SHALL have parameter EAw, default 8: endpoint address width.
REQ-004 SHALL have parameter PCK_SIZw, default 5: packet size width, in flits.
REQ-005 SHALL have parameter Dw, default 32: packet data width.
REQ-006 SHALL have parameter MIN_SIZE, default 2: minimum legal packet size, in flits.
REQ-007 SHALL have port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-008 SHALL have port reset, input, 1 bit: synchronous, active-low.
REQ-009 SHALL have port req_valid, input, N bits: per-requester packet request.
REQ-010 SHALL have port req_vc, input, N*Vw bits: binary VC per requester (slice i = [i*Vw +: Vw]).
REQ-011 SHALL have port req_size, input, N*PCK_SIZw bits: flit count per requester.
REQ-012 SHALL have port req_dest, input, N*EAw bits: destination endpoint address per requester.
REQ-013 SHALL have port req_data, input, N*Dw bits: packet data per requester.
REQ-014 SHALL have port req_ack, output, N bits: one-cycle acceptance pulse.
REQ-015 SHALL have port req_err, output, N bits: one-cycle rejection pulse, asserted together with req_ack.
REQ-016 SHALL have port inj_ready, input, V bits: per-VC injector ready.
REQ-017 SHALL have port pck_wr, output, 1 bit: packet write strobe to the injector.
REQ-018 SHALL have ports pck_vc (output, V bits, one-hot), pck_size (output, PCK_SIZw bits), pck_endp_addr (output, EAw bits) and pck_data (output, Dw bits); all are registered.
REQ-019 SHALL have ports busy (output, 1 bit) and issued_cnt (output, 16 bits).

Function
REQ-020 SHALL implement an FSM with states IDLE, ISSUE and GAP.
REQ-021 Illegal request: requester i is illegal when req_size_i < MIN_SIZE or req_vc_i >= V.
REQ-022 Eligibility: requester i is eligible when req_valid[i] & (illegal_i | inj_ready[req_vc_i]).
REQ-023 Arbitration in IDLE: round-robin; the winner is the first eligible index at or after pointer ptr, wrapping N-1 -> 0.
REQ-024 Pointer update: on any grant, ptr <= (winner + 1) mod N; otherwise ptr is held.
REQ-025 Acknowledge: req_ack[winner] SHALL be asserted combinationally in the IDLE grant cycle; the requester holds its fields stable until it sees ack.
REQ-026 Legal grant: capture req_vc (as one-hot), req_size, req_dest and req_data into the output registers; next state is ISSUE.
REQ-027 Illegal grant: req_err[winner] = 1 in the same cycle as ack; no capture; state stays IDLE; issued_cnt is unchanged.
REQ-028 ISSUE: pck_wr = 1 for exactly one cycle; issued_cnt increments (16-bit, wraps 0xFFFF -> 0); next state is GAP.
REQ-029 GAP: pck_wr = 0 for exactly one cycle; next state is IDLE.
REQ-030 Throughput: the peak legal packet rate is one per 3 cycles.
REQ-031 The pck_* fields SHALL hold their last values outside ISSUE.
REQ-032 Ready rationale: inj_ready is sampled only in IDLE. It cannot fall before ISSUE because the only writer to the injector is this block. The GAP cycle lets the injector's ready reflect the issued packet before the next arbitration.
REQ-033 No grant occurs in ISSUE or GAP; req_ack and req_err are 0 in those states.
REQ-034 busy = 1 in ISSUE and GAP, 0 in IDLE.
REQ-035 No eligible requester in IDLE: no ack and no state change.
REQ-036 req_valid dropped before ack: no effect; arbitration is re-evaluated every IDLE cycle.

Reset
REQ-037 While reset = 0 at a clk edge: state <= IDLE, ptr <= 0, issued_cnt <= 0, pck_wr <= 0, pck_vc/pck_size/pck_endp_addr/pck_data <= 0.
REQ-038 While reset = 0, req_ack and req_err SHALL be forced to 0.
REQ-039 Reset asserted in ISSUE or GAP: the packet is abandoned; pck_wr = 0 from the next cycle and no pulse occurs after reset releases.
REQ-040 First grant after reset: the first IDLE cycle with reset = 1 may grant.

Verification
REQ-041 Scenario, contention: N=4; all requesters valid, vc=0, size=4; inj_ready=2'b11 -> acks on requesters 0, 1, 2, 3, 0 at cycles t, t+3, t+6, t+9, t+12; pck_wr at t+1, t+4, and so on; issued_cnt=5.
REQ-042 Scenario, blocked VC: requester 1 on vc=1 with inj_ready=2'b01, requester 2 on vc=0 -> requester 2 granted and requester 1 waits; raising inj_ready[1] -> requester 1 granted at the next IDLE cycle.
REQ-043 Scenario, illegal size: requester 3 size=1 (below MIN_SIZE=2) -> req_ack[3]=req_err[3]=1 for one cycle; no pck_wr; issued_cnt unchanged; ptr advances to 0.
REQ-044 Scenario, field capture: requester 2 issues dest=0x15, data=0xDEADBEEF, size=3, vc=1 -> during ISSUE pck_vc=2'b10, pck_endp_addr=0x15, pck_data=0xDEADBEEF, pck_size=3.
REQ-045 Scenario, reset in ISSUE: reset=0 during the ISSUE cycle -> pck_wr=0 and issued_cnt=0 afterwards; after release, requester 0 is granted first.
REQ-046 Scenario, counter wrap: preload issued_cnt to 0xFFFF via 65535 issues, or use a force in the bench -> one more issue yields 0x0000.
